// File: rtl/cdb_fifo_arbiter_if.sv
// cdb_fifo_arbiter_if: push, FIFO and CDB-consumer signal bundle for cdb_fifo_arbiter
interface cdb_fifo_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int DATA0SIZE = 32,
    parameter int DATA1SIZE = 8
);
    localparam int GW = $clog2(NREQ);
    logic [NREQ-1:0]           i_req;
    logic [NREQ*DATA0SIZE-1:0] i_req_data0;
    logic [NREQ*DATA1SIZE-1:0] i_req_data1;
    logic [NREQ-1:0]           o_req_ack;
    logic [GW-1:0]             o_grant_idx;
    logic                      o_fifo_wrt_en;
    logic [DATA0SIZE-1:0]      o_fifo_data0;
    logic [DATA1SIZE-1:0]      o_fifo_data1;
    logic                      i_fifo_full;
    logic                      i_fifo_empty;
    logic                      o_fifo_rd_en;
    logic [DATA0SIZE-1:0]      i_fifo_data0;
    logic [DATA1SIZE-1:0]      i_fifo_data1;
    logic                      o_cons_valid;
    logic                      i_cons_ready;
    logic [DATA0SIZE-1:0]      o_cons_data0;
    logic [DATA1SIZE-1:0]      o_cons_data1;
    logic                      i_flush;
    logic                      o_flush_busy;

    modport slave (
        input  i_req, i_req_data0, i_req_data1, i_fifo_full, i_fifo_empty,
               i_fifo_data0, i_fifo_data1, i_cons_ready, i_flush,
        output o_req_ack, o_grant_idx, o_fifo_wrt_en, o_fifo_data0, o_fifo_data1,
               o_fifo_rd_en, o_cons_valid, o_cons_data0, o_cons_data1, o_flush_busy
    );

    modport master (
        output i_req, i_req_data0, i_req_data1, i_fifo_full, i_fifo_empty,
               i_fifo_data0, i_fifo_data1, i_cons_ready, i_flush,
        input  o_req_ack, o_grant_idx, o_fifo_wrt_en, o_fifo_data0, o_fifo_data1,
               o_fifo_rd_en, o_cons_valid, o_cons_data0, o_cons_data1, o_flush_busy
    );
endinterface

// File: rtl/cdb_fifo_arbiter.sv
// cdb_fifo_arbiter: round-robin push arbiter, CDB drain and flush sequencer for the shared result FIFO
module cdb_fifo_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA0SIZE = 32,
    parameter int DATA1SIZE = 8
) (
    input logic              clk,
    input logic              rstn,
    cdb_fifo_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [GW-1:0] rr_ptr, grant;
    logic          found, run, flushing, push;

    always_comb begin
        logic [GW:0]   sum;
        logic [GW-1:0] cand;
        sum   = '0;
        cand  = '0;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sum  = {1'b0, rr_ptr} + (GW+1)'(i);
            cand = sum >= (GW+1)'(NREQ) ? GW'(sum - (GW+1)'(NREQ)) : GW'(sum);
            if (!found && bus.i_req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Outputs are gated by rstn so nothing is acked or popped while reset is held.
    assign run      = rstn && state == RUN;
    assign flushing = rstn && state == FLUSH;
    assign push     = run && !bus.i_flush && !bus.i_fifo_full && found;

    assign bus.o_fifo_wrt_en = push;
    assign bus.o_req_ack     = push ? NREQ'(1) << grant : '0;
    assign bus.o_grant_idx   = push ? grant : '0;
    assign bus.o_fifo_data0  = push ? bus.i_req_data0[grant*DATA0SIZE +: DATA0SIZE] : '0;
    assign bus.o_fifo_data1  = push ? bus.i_req_data1[grant*DATA1SIZE +: DATA1SIZE] : '0;

    assign bus.o_cons_valid  = run && !bus.i_fifo_empty;
    assign bus.o_cons_data0  = bus.o_cons_valid ? bus.i_fifo_data0 : '0;
    assign bus.o_cons_data1  = bus.o_cons_valid ? bus.i_fifo_data1 : '0;
    assign bus.o_fifo_rd_en  = run ? bus.o_cons_valid && bus.i_cons_ready : flushing && !bus.i_fifo_empty;
    assign bus.o_flush_busy  = flushing;

    assign state_nxt = state == RUN ? (bus.i_flush ? FLUSH : RUN)
                                    : (!bus.i_flush && bus.i_fifo_empty ? RUN : FLUSH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= RUN;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (push)
                rr_ptr <= grant == GW'(NREQ-1) ? '0 : grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_fifo_arbiter.sv
// tb_cdb_fifo_arbiter: scoreboard bench with a behavioural FIFO behind the arbiter
module tb_cdb_fifo_arbiter;
    typedef struct {
        int          idx;
        logic [31:0] d0;
        logic [7:0]  d1;
    } grant_t;

    logic        clk;
    logic        rstn;
    logic        force_full;
    logic [31:0] rd0 [4];
    logic [7:0]  rd1 [4];
    logic [39:0] mem [8];
    logic [39:0] head;
    int          wp, rp, cnt;
    int          vectors = 0;
    int          errors  = 0;
    grant_t      exp_q [$];
    logic [39:0] cons_q [$];
    grant_t      e;
    logic [39:0] c;
    logic [3:0]  oh;

    cdb_fifo_arbiter_if #(.NREQ(4), .DATA0SIZE(32), .DATA1SIZE(8)) bus ();
    cdb_fifo_arbiter #(.NREQ(4), .DATA0SIZE(32), .DATA1SIZE(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_req_data0  = {rd0[3], rd0[2], rd0[1], rd0[0]};
    assign bus.i_req_data1  = {rd1[3], rd1[2], rd1[1], rd1[0]};
    assign head             = mem[rp];
    assign bus.i_fifo_empty = cnt == 0;
    assign bus.i_fifo_full  = force_full || cnt >= 8;
    assign bus.i_fifo_data0 = head[39:8];
    assign bus.i_fifo_data1 = head[7:0];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp  <= 0;
            rp  <= 0;
            cnt <= 0;
        end else begin
            if (bus.o_fifo_rd_en && cnt > 0)
                rp <= (rp + 1) % 8;
            if (bus.o_fifo_wrt_en && cnt < 8) begin
                mem[wp] <= {bus.o_fifo_data0, bus.o_fifo_data1};
                wp      <= (wp + 1) % 8;
            end
            cnt <= cnt + ((bus.o_fifo_wrt_en && cnt < 8) ? 1 : 0) - ((bus.o_fifo_rd_en && cnt > 0) ? 1 : 0);
        end
    end

    // Pops compare against the oldest accepted push; pushes must match the next expected grant.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            cons_q.delete();
        end else begin
            if (bus.o_fifo_rd_en) begin
                if (cons_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL pop_underflow: rd_en=1 with nothing pushed");
                end else begin
                    c = cons_q.pop_front();
                    if (!bus.o_flush_busy) begin
                        vectors++;
                        if ({bus.o_cons_data0, bus.o_cons_data1} !== c) begin
                            errors++;
                            $display("FAIL cons_data: got %h/%h want %h/%h", bus.o_cons_data0, bus.o_cons_data1, c[39:8], c[7:0]);
                        end
                    end
                end
            end
            if (bus.o_fifo_wrt_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_push: idx=%0d ack=%b", bus.o_grant_idx, bus.o_req_ack);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e.idx;
                    if (bus.o_grant_idx !== 2'(e.idx) || bus.o_req_ack !== oh ||
                        bus.o_fifo_data0 !== e.d0 || bus.o_fifo_data1 !== e.d1) begin
                        errors++;
                        $display("FAIL push: got idx=%0d ack=%b %h/%h want idx=%0d ack=%b %h/%h",
                                 bus.o_grant_idx, bus.o_req_ack, bus.o_fifo_data0, bus.o_fifo_data1,
                                 e.idx, oh, e.d0, e.d1);
                    end
                    cons_q.push_back({e.d0, e.d1});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int k);
        exp_q.push_back('{k, rd0[k], rd1[k]});
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d expected grants never seen, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        force_full = 1'b0;
        bus.i_req = 4'b1111;
        bus.i_cons_ready = 1'b1;
        bus.i_flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd0[k] = 32'h11 * (k + 1);
            rd1[k] = 8'(k + 1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.o_req_ack !== 4'b0000 || bus.o_fifo_wrt_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_ack: ack=%b wrt_en=%b want 0000/0", bus.o_req_ack, bus.o_fifo_wrt_en);
        end
        vectors++;
        if ({bus.o_grant_idx, bus.o_fifo_data0, bus.o_fifo_data1} !== 42'd0) begin
            errors++;
            $display("FAIL rst_wdata: idx=%0d data=%h/%h want 0", bus.o_grant_idx, bus.o_fifo_data0, bus.o_fifo_data1);
        end
        vectors++;
        if ({bus.o_cons_valid, bus.o_fifo_rd_en, bus.o_flush_busy, bus.o_cons_data0, bus.o_cons_data1} !== 43'd0) begin
            errors++;
            $display("FAIL rst_read: valid=%b rd_en=%b busy=%b data=%h/%h want 0",
                     bus.o_cons_valid, bus.o_fifo_rd_en, bus.o_flush_busy, bus.o_cons_data0, bus.o_cons_data1);
        end
        step();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) expect_grant(k);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_req_ack !== (4'b0001 << k) || bus.o_grant_idx !== 2'(k)) begin
                errors++;
                $display("FAIL rst_order%0d: ack=%b idx=%0d want ack=%b idx=%0d", k, bus.o_req_ack, bus.o_grant_idx, 4'b0001 << k, k);
            end
            if (k == 0) begin
                vectors++;
                if (bus.o_cons_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL empty_push_valid: cons_valid=%b want 0", bus.o_cons_valid);
                end
            end
            step();
            bus.i_req[k] = 1'b0;
        end
        check_drained("reset");
    endtask

    task automatic test_fairness();
        bus.i_req = 4'b0101;
        for (int i = 0; i < 6; i++) expect_grant(i % 2 == 0 ? 0 : 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_grant_idx !== 2'(i % 2 == 0 ? 0 : 2)) begin
                errors++;
                $display("FAIL rr_order%0d: idx=%0d want %0d", i, bus.o_grant_idx, i % 2 == 0 ? 0 : 2);
            end
            step();
        end
        bus.i_req = 4'b0000;
        check_drained("fairness");
    endtask

    task automatic test_full();
        force_full = 1'b1;
        bus.i_req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_fifo_wrt_en !== 1'b0 || bus.o_req_ack !== 4'b0000) begin
                errors++;
                $display("FAIL full_block: wrt_en=%b ack=%b want 0/0000", bus.o_fifo_wrt_en, bus.o_req_ack);
            end
            step();
        end
        force_full = 1'b0;
        expect_grant(2);
        @(negedge clk);
        vectors++;
        if (bus.o_req_ack !== 4'b0100) begin
            errors++;
            $display("FAIL full_release: ack=%b want 0100", bus.o_req_ack);
        end
        step();
        bus.i_req = 4'b0000;
        check_drained("full");
    endtask

    task automatic test_consumer();
        repeat (3) step();
        bus.i_cons_ready = 1'b0;
        rd0[3] = 32'hDEADBEEF;
        rd1[3] = 8'h2A;
        bus.i_req = 4'b1000;
        expect_grant(3);
        step();
        bus.i_req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_cons_valid !== 1'b1 || bus.o_fifo_rd_en !== 1'b0 ||
                bus.o_cons_data0 !== 32'hDEADBEEF || bus.o_cons_data1 !== 8'h2A) begin
                errors++;
                $display("FAIL cons_hold%0d: valid=%b rd_en=%b data=%h/%h want 1/0 deadbeef/2a",
                         i, bus.o_cons_valid, bus.o_fifo_rd_en, bus.o_cons_data0, bus.o_cons_data1);
            end
            step();
        end
        bus.i_cons_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL cons_pop: rd_en=%b want 1", bus.o_fifo_rd_en);
        end
        step();
        @(negedge clk);
        vectors++;
        if (bus.o_fifo_rd_en !== 1'b0 || bus.o_cons_valid !== 1'b0) begin
            errors++;
            $display("FAIL cons_once: rd_en=%b valid=%b want 0/0", bus.o_fifo_rd_en, bus.o_cons_valid);
        end
        step();
        rd0[3] = 32'h44;
        rd1[3] = 8'h04;
        check_drained("consumer");
    endtask

    task automatic test_flush_drain();
        bus.i_cons_ready = 1'b0;
        bus.i_req = 4'b1111;
        expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
        repeat (5) begin
            @(negedge clk);
            step();
        end
        bus.i_req = 4'b0001;
        bus.i_flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_fifo_wrt_en !== 1'b0 || bus.o_flush_busy !== 1'b0 || bus.o_fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_entry: wrt_en=%b busy=%b rd_en=%b want 0/0/0", bus.o_fifo_wrt_en, bus.o_flush_busy, bus.o_fifo_rd_en);
        end
        step();
        bus.i_flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_flush_busy !== 1'b1 || bus.o_fifo_rd_en !== 1'b1 || bus.o_cons_valid !== 1'b0 ||
                bus.o_req_ack !== 4'b0000 || bus.o_cons_data0 !== 32'd0) begin
                errors++;
                $display("FAIL flush_drain%0d: busy=%b rd_en=%b valid=%b ack=%b data0=%h want 1/1/0/0000/0",
                         i, bus.o_flush_busy, bus.o_fifo_rd_en, bus.o_cons_valid, bus.o_req_ack, bus.o_cons_data0);
            end
            step();
        end
        @(negedge clk);
        vectors++;
        if (bus.o_flush_busy !== 1'b1 || bus.o_fifo_rd_en !== 1'b0 || bus.o_req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL flush_tail: busy=%b rd_en=%b ack=%b want 1/0/0000", bus.o_flush_busy, bus.o_fifo_rd_en, bus.o_req_ack);
        end
        step();
        expect_grant(0);
        @(negedge clk);
        vectors++;
        if (bus.o_flush_busy !== 1'b0 || bus.o_req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL flush_exit: busy=%b ack=%b want 0/0001", bus.o_flush_busy, bus.o_req_ack);
        end
        step();
        bus.i_req = 4'b0000;
        bus.i_cons_ready = 1'b1;
        @(negedge clk);
        step();
        check_drained("flush");
    endtask

    task automatic test_reset_mid_flush();
        bus.i_cons_ready = 1'b0;
        bus.i_req = 4'b0111;
        expect_grant(1); expect_grant(2); expect_grant(0);
        repeat (3) begin
            @(negedge clk);
            step();
        end
        bus.i_req = 4'b0000;
        bus.i_flush = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        vectors++;
        if (bus.o_flush_busy !== 1'b1 || bus.o_fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_flush_busy: busy=%b rd_en=%b want 1/1", bus.o_flush_busy, bus.o_fifo_rd_en);
        end
        step();
        rstn = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_req = 4'b1111;
        #1;
        vectors++;
        if (bus.o_flush_busy !== 1'b0 || bus.o_fifo_rd_en !== 1'b0 || bus.o_req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL mid_flush_rst: busy=%b rd_en=%b ack=%b want 0/0/0000", bus.o_flush_busy, bus.o_fifo_rd_en, bus.o_req_ack);
        end
        step();
        rstn = 1'b1;
        expect_grant(0);
        @(negedge clk);
        vectors++;
        if (bus.o_req_ack !== 4'b0001 || bus.o_flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: ack=%b busy=%b want 0001/0", bus.o_req_ack, bus.o_flush_busy);
        end
        step();
        bus.i_req = 4'b0000;
        bus.i_cons_ready = 1'b1;
        repeat (2) step();
        check_drained("mid_flush");
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_full();
        test_consumer();
        test_flush_drain();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
